mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/mult_div_unit_div_step.sv | 19 +
 rtl/mult_div_unit.sv | 129 ++++++++++++
 tb/tb_mult_div_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and operand helpers for the multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic [4:0] LAST_ITER = 5'd31;

  // Magnitude of x; sgn selects two's-complement interpretation.
  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration: shift in next dividend bit, subtract if it fits.
// Purely combinational; no flow control.
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic        fits;

  assign shifted = {rem_i, quo_i[31]};
  assign fits    = (shifted >= {1'b0, divisor});
  assign rem_o   = fits ? (shifted[31:0] - divisor) : shifted[31:0];
  assign quo_o   = {quo_i[30:0], fits};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide writing HI/LO; 33 clocks accept-to-write.
// No backpressure: start is dropped while busy or for reserved ops.
module mult_div_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state, state_nxt;
  logic        accept_it, accept_mt;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  cnt;
  logic [63:0] work;

  logic [31:0] amag, bmag;
  logic [32:0] sum;
  logic [63:0] mul_nxt, product;
  logic [31:0] rem_nxt, quo_nxt;
  logic        neg_res, neg_rem;
  logic [31:0] hi_fix, lo_fix;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    accept_it = 1'b0;
    accept_mt = 1'b0;
    case (state)
      IDLE: begin
        if (start && !op[2]) begin
          accept_it = 1'b1;
          state_nxt = CALC;
        end
        accept_mt = start && ((op == OP_MTHI) || (op == OP_MTLO));
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST_ITER) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // op_q[0] set means unsigned; op_q[1] set means divide.
  assign amag = mag(a_q, ~op_q[0]);
  assign bmag = mag(b_q, ~op_q[0]);

  // work holds {acc, multiplier} for multiply and {rem, dividend/quotient} for divide.
  assign sum     = {1'b0, work[63:32]} + {1'b0, (work[0] ? amag : 32'd0)};
  assign mul_nxt = {sum, work[31:1]};

  div_step u_div_step (
    .rem_i   (work[63:32]),
    .quo_i   (work[31:0]),
    .divisor (bmag),
    .rem_o   (rem_nxt),
    .quo_o   (quo_nxt)
  );

  assign neg_res = ~op_q[0] & (a_q[31] ^ b_q[31]);
  assign neg_rem = ~op_q[0] & a_q[31];
  assign product = neg_res ? (~work + 64'd1) : work;

  always_comb begin
    hi_fix = product[63:32];
    lo_fix = product[31:0];
    if (op_q[1]) begin
      if (b_q == 32'd0) begin
        hi_fix = a_q;
        lo_fix = 32'hFFFF_FFFF;
      end else begin
        lo_fix = neg_res ? (~work[31:0] + 32'd1) : work[31:0];
        hi_fix = neg_rem ? (~work[63:32] + 32'd1) : work[63:32];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= 2'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      cnt  <= 5'd0;
      work <= 64'd0;
      hi   <= 32'd0;
      lo   <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_it) begin
        op_q <= op[1:0];
        a_q  <= a;
        b_q  <= b;
        cnt  <= 5'd0;
        work <= {32'd0, (op[1] ? mag(a, ~op[0]) : mag(b, ~op[0]))};
      end else if (state == CALC) begin
        cnt  <= cnt + 5'd1;
        work <= op_q[1] ? {rem_nxt, quo_nxt} : mul_nxt;
      end else if (state == FIX) begin
        hi   <= hi_fix;
        lo   <= lo_fix;
        done <= 1'b1;
      end
      if (accept_mt) begin
        if (op[0]) lo <= a;
        else       hi <= a;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        start;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .op    (op),
    .start (start),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Start asserted for one edge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles from the accepting edge until done is seen; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    #12;
    n_cmp++; if (hi !== 32'd0)  begin n_bad++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'd0)  begin n_bad++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int cyc;
    issue(MULT, 32'hFFFF_FFFD, 32'd5);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mult_busy: got %b want 1", busy); end
    wait_done(cyc);
    n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL mult_latency: got %0d want 33", cyc); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mult_busy_end: got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mult_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_multu;
    int cyc;
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL multu_latency: got %0d want 33", cyc); end
    n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    n_cmp++; if (lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo: got %h want 00000001", lo); end
  endtask

  task automatic test_div;
    int cyc;
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL div_latency: got %0d want 33", cyc); end
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
  endtask

  task automatic test_div_zero;
    int cyc;
    issue(DIV, 32'hFFFF_FFFB, 32'd0);
    wait_done(cyc);
    n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL divz_latency: got %0d want 33", cyc); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divz_lo: got %h want ffffffff", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFB) begin n_bad++; $display("FAIL divz_hi: got %h want fffffffb", hi); end
  endtask

  task automatic test_div_overflow;
    int cyc;
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL divov_timeout: got %0d want 33", cyc); end
    n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL divov_lo: got %h want 80000000", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL divov_hi: got %h want 0", hi); end
  endtask

  task automatic test_move;
    logic [31:0] hi0;
    hi0 = hi;
    issue(MTLO, 32'h1234_5678, 32'd0);
    n_cmp++; if (lo !== 32'h1234_5678) begin n_bad++; $display("FAIL mtlo_lo: got %h want 12345678", lo); end
    n_cmp++; if (hi !== hi0) begin n_bad++; $display("FAIL mtlo_hi: got %h want %h", hi, hi0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy: got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mtlo_quiet: got done=%b busy=%b want 0 0", done, busy);
    end
    issue(MTHI, 32'hCAFE_F00D, 32'd0);
    n_cmp++; if (hi !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL mthi_hi: got %h want cafef00d", hi); end
    n_cmp++; if (lo !== 32'h1234_5678) begin n_bad++; $display("FAIL mthi_lo: got %h want 12345678", lo); end
  endtask

  task automatic test_reserved;
    issue(3'b110, 32'h1111_1111, 32'd3);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rsv110_busy: got %b want 0", busy); end
    issue(3'b111, 32'h2222_2222, 32'd3);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rsv111_busy: got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (hi !== 32'hCAFE_F00D || lo !== 32'h1234_5678) begin
      n_bad++; $display("FAIL rsv_hold: got %h_%h want cafef00d_12345678", hi, lo);
    end
  endtask

  task automatic test_busy_ignore;
    int cyc, busy_cnt;
    cyc = -1; busy_cnt = 0;
    @(negedge clk);
    op = MULT; a = 32'hFFFF_FFFD; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 4) begin op = MTHI; a = 32'hDEAD_BEEF; start = 1'b1; end
      if (n == 5) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin cyc = n; break; end
    end
    n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL ign_latency: got %0d want 33", cyc); end
    n_cmp++; if (busy_cnt != 33) begin n_bad++; $display("FAIL ign_busy_cycles: got %0d want 33", busy_cnt); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL ign_hi: got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL ign_lo: got %h want fffffff1", lo); end
  endtask

  task automatic test_operand_change;
    int cyc;
    issue(DIVU, 32'd100, 32'd7);
    op = MULT; a = 32'h8765_4321; b = 32'd0;
    wait_done(cyc);
    n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL opchg_latency: got %0d want 33", cyc); end
    n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL opchg_lo: got %h want 0000000e", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_bad++; $display("FAIL opchg_hi: got %h want 00000002", hi); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(MULTU, 32'd6, 32'd7);
    wait_done(cyc);
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd42) begin
      n_bad++; $display("FAIL b2b_mul: got %h_%h want 00000000_0000002a", hi, lo);
    end
    // Start lands in the done cycle, where the unit is already idle.
    op = DIV; a = 32'd100; b = 32'hFFFF_FFF9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    wait_done(cyc);
    n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL b2b_latency: got %0d want 33", cyc); end
    n_cmp++; if (lo !== 32'hFFFF_FFF2 || hi !== 32'd2) begin
      n_bad++; $display("FAIL b2b_div: got %h_%h want 00000002_fffffff2", hi, lo);
    end
  endtask

  task automatic test_reset_mid;
    bit seen_done, seen_busy;
    seen_done = 1'b0; seen_busy = 1'b0;
    issue(DIV, 32'd50, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++; $display("FAIL rstmid_hilo: got %h_%h want 0_0", hi, lo);
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    n_cmp++; if (seen_done) begin n_bad++; $display("FAIL rstmid_done: got 1 want 0"); end
    n_cmp++; if (seen_busy) begin n_bad++; $display("FAIL rstmid_busy_after: got 1 want 0"); end
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++; $display("FAIL rstmid_hold: got %h_%h want 0_0", hi, lo);
    end
  endtask

  task automatic test_after_reset;
    int cyc;
    issue(DIVU, 32'd100, 32'd0);
    wait_done(cyc);
    n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL postrst_latency: got %0d want 33", cyc); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL postrst_lo: got %h want ffffffff", lo); end
    n_cmp++; if (hi !== 32'd100) begin n_bad++; $display("FAIL postrst_hi: got %h want 00000064", hi); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div_zero;
    test_div_overflow;
    test_move;
    test_reserved;
    test_busy_ignore;
    test_operand_change;
    test_back_to_back;
    test_reset_mid;
    test_after_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
